// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: host config, engine handshakes/pixel streams and vga port of the scene sequencer
interface draw_sequencer_if;
  logic       start, done, error;
  logic [2:0] colour;
  logic [7:0] centre_x, diameter;
  logic [6:0] centre_y;
  logic       fill_start, fill_done, fill_plot;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic [2:0] fill_colour;
  logic       shp_start, shp_done, shp_plot;
  logic [7:0] shp_x, shp_centre_x, shp_diameter;
  logic [6:0] shp_y, shp_centre_y;
  logic [2:0] shp_colour, shp_cfg_colour;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
`ifdef DRAW_SEQ_PIXCOUNT_EN
  logic [15:0] pixel_count;
`endif
  modport master (
`ifdef DRAW_SEQ_PIXCOUNT_EN
    input pixel_count,
`endif
    output start, colour, centre_x, centre_y, diameter,
    output fill_done, fill_x, fill_y, fill_colour, fill_plot,
    output shp_done, shp_x, shp_y, shp_colour, shp_plot,
    input done, error, fill_start, shp_start,
    input shp_cfg_colour, shp_centre_x, shp_centre_y, shp_diameter,
    input vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
`ifdef DRAW_SEQ_PIXCOUNT_EN
    output pixel_count,
`endif
    input start, colour, centre_x, centre_y, diameter,
    input fill_done, fill_x, fill_y, fill_colour, fill_plot,
    input shp_done, shp_x, shp_y, shp_colour, shp_plot,
    output done, error, fill_start, shp_start,
    output shp_cfg_colour, shp_centre_x, shp_centre_y, shp_diameter,
    output vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/draw_sequencer.sv
// draw_sequencer: runs fill then shape engine, muxes and clips their pixels onto the vga port.
// Optional pixel_count output enabled by DRAW_SEQ_PIXCOUNT_EN.
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int TIMEOUT  = 100000
) (
  input logic clk,
  input logic rst_n,
  draw_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FILL, FILL_REL, SHAPE, SHAPE_REL, DONE} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [WW-1:0] wd;
  logic wd_exp, in_fill, in_shp, src_plot;
  logic [7:0] src_x;
  logic [6:0] src_y;
  logic [2:0] src_colour;
  assign wd_exp = wd == WW'(TIMEOUT - 1);
  assign in_fill = state == FILL;
  assign in_shp = state == SHAPE;
  assign src_x = in_shp ? bus.shp_x : bus.fill_x;
  assign src_y = in_shp ? bus.shp_y : bus.fill_y;
  assign src_colour = in_shp ? bus.shp_colour : bus.fill_colour;
  assign src_plot = in_shp ? bus.shp_plot : in_fill && bus.fill_plot;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.fill_start <= 1'b0;
      bus.shp_start <= 1'b0;
      bus.shp_cfg_colour <= '0;
      bus.shp_centre_x <= '0;
      bus.shp_centre_y <= '0;
      bus.shp_diameter <= '0;
      wd <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= FILL;
          bus.fill_start <= 1'b1;
          bus.error <= 1'b0;
          wd <= '0;
          bus.shp_cfg_colour <= bus.colour;
          bus.shp_centre_x <= bus.centre_x;
          bus.shp_centre_y <= bus.centre_y;
          bus.shp_diameter <= bus.diameter;
        end
        FILL, SHAPE: if (in_fill ? bus.fill_done : bus.shp_done) begin
          state <= in_fill ? FILL_REL : SHAPE_REL;
          bus.fill_start <= 1'b0;
          bus.shp_start <= 1'b0;
        end else if (wd_exp) begin
          state <= DONE;
          bus.fill_start <= 1'b0;
          bus.shp_start <= 1'b0;
          bus.error <= 1'b1;
          bus.done <= 1'b1;
        end else begin
          wd <= wd + 1'b1;
        end
        FILL_REL: begin
          state <= SHAPE;
          bus.shp_start <= 1'b1;
          wd <= '0;
        end
        SHAPE_REL: begin
          state <= DONE;
          bus.done <= 1'b1;
        end
        DONE: if (!bus.start) begin
          state <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Coordinates follow the source every cycle; only plot is gated by state and clipping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vga_plot <= 1'b0;
      bus.vga_x <= '0;
      bus.vga_y <= '0;
      bus.vga_colour <= '0;
    end else begin
      bus.vga_plot <= src_plot && 32'(src_x) < SCREEN_W && 32'(src_y) < SCREEN_H;
      bus.vga_x <= src_x;
      bus.vga_y <= src_y;
      bus.vga_colour <= src_colour;
    end
  end
`ifdef DRAW_SEQ_PIXCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.pixel_count <= '0;
    else if (state == IDLE && bus.start) bus.pixel_count <= '0;
    else if (bus.vga_plot && bus.pixel_count != 16'hFFFF) bus.pixel_count <= bus.pixel_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed checks of sequencing, config latch, clipping, watchdog and async reset
module tb_draw_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  draw_sequencer_if bus();
  draw_sequencer_if wbus();
  draw_sequencer u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  draw_sequencer #(.TIMEOUT(50)) u_wd (.clk(clk), .rst_n(rst_n), .bus(wbus));
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       exp_p;
  } pix_t;
  pix_t tbl[7];
  int tests = 0, fails = 0;
  bit fill_auto, shp_auto;
  int fill_n, shp_n, fcnt, scnt;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic engines();
    if (fill_auto) begin
      if (bus.fill_start) begin
        if (fcnt < fill_n) begin
          bus.fill_x = 8'(fcnt % 160);
          bus.fill_y = 7'(fcnt / 160);
          bus.fill_colour = 3'(fcnt);
          bus.fill_plot = 1'b1;
          fcnt++;
        end else begin
          bus.fill_plot = 1'b0;
          bus.fill_done = 1'b1;
        end
      end else begin
        fcnt = 0;
        bus.fill_plot = 1'b0;
        bus.fill_done = 1'b0;
      end
    end
    if (shp_auto) begin
      if (bus.shp_start) begin
        if (scnt < shp_n) begin
          bus.shp_x = 8'(scnt % 150);
          bus.shp_y = 7'(scnt / 150);
          bus.shp_colour = 3'(scnt);
          bus.shp_plot = 1'b1;
          scnt++;
        end else begin
          bus.shp_plot = 1'b0;
          bus.shp_done = 1'b1;
        end
      end else begin
        scnt = 0;
        bus.shp_plot = 1'b0;
        bus.shp_done = 1'b0;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    engines();
  endtask
  initial begin
    int cyc, t_fall, t_rise, cfg_bad;
    logic prev_f, prev_s, sh;
    tbl[0] = '{8'd160, 7'd5,   3'd1, 1'b1, 1'b0};
    tbl[1] = '{8'd159, 7'd119, 3'd2, 1'b1, 1'b1};
    tbl[2] = '{8'd0,   7'd0,   3'd3, 1'b1, 1'b1};
    tbl[3] = '{8'd159, 7'd120, 3'd4, 1'b1, 1'b0};
    tbl[4] = '{8'd255, 7'd127, 3'd7, 1'b1, 1'b0};
    tbl[5] = '{8'd100, 7'd50,  3'd5, 1'b0, 1'b0};
    tbl[6] = '{8'd100, 7'd50,  3'd6, 1'b1, 1'b1};
    {bus.start, bus.colour, bus.centre_x, bus.centre_y, bus.diameter} = '0;
    {bus.fill_done, bus.fill_x, bus.fill_y, bus.fill_colour, bus.fill_plot} = '0;
    {bus.shp_done, bus.shp_x, bus.shp_y, bus.shp_colour, bus.shp_plot} = '0;
    {wbus.start, wbus.colour, wbus.centre_x, wbus.centre_y, wbus.diameter} = '0;
    {wbus.fill_done, wbus.fill_x, wbus.fill_y, wbus.fill_colour, wbus.fill_plot} = '0;
    {wbus.shp_done, wbus.shp_x, wbus.shp_y, wbus.shp_colour, wbus.shp_plot} = '0;
    fill_auto = 1; shp_auto = 1; fill_n = 19200; shp_n = 500; fcnt = 0; scnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst done", bus.done, 0);
    check("rst error", bus.error, 0);
    check("rst starts", {bus.fill_start, bus.shp_start}, 0);
    check("rst vga", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    check("rst cfg", {bus.shp_cfg_colour, bus.shp_centre_x, bus.shp_centre_y, bus.shp_diameter}, 0);
    #3 rst_n = 1'b1;
    // Run 1: full-size stub engines, config changed after the latch
    bus.start = 1; bus.colour = 3'b010; bus.centre_x = 30; bus.centre_y = 20; bus.diameter = 80;
    tick();
    check("run1 fill_start", bus.fill_start, 1);
    check("run1 shp_start idle", bus.shp_start, 0);
    bus.colour = 0; bus.centre_x = 0; bus.centre_y = 0; bus.diameter = 0;
    cyc = 0; t_fall = -1; t_rise = -1; cfg_bad = 0; prev_f = 1; prev_s = 0;
    while (cyc < 30000 && !bus.done) begin
      tick();
      cyc++;
      if (prev_f && !bus.fill_start && t_fall < 0) t_fall = cyc;
      if (!prev_s && bus.shp_start && t_rise < 0) t_rise = cyc;
      if (bus.shp_start && {bus.shp_cfg_colour, bus.shp_centre_x, bus.shp_centre_y, bus.shp_diameter} !== {3'b010, 8'd30, 7'd20, 8'd80}) cfg_bad++;
      prev_f = bus.fill_start;
      prev_s = bus.shp_start;
    end
    check("run1 done", bus.done, 1);
    check("run1 error", bus.error, 0);
    check("run1 fill seen", t_fall > 0, 1);
    check("run1 gap", 32'(t_rise - t_fall), 1);
    check("run1 cfg held", cfg_bad, 0);
    check("run1 cfg final", {bus.shp_cfg_colour, bus.shp_centre_x, bus.shp_centre_y, bus.shp_diameter}, {3'b010, 8'd30, 7'd20, 8'd80});
`ifdef DRAW_SEQ_PIXCOUNT_EN
    check("run1 pixel_count", bus.pixel_count, 19700);
`endif
    bus.start = 0;
    tick();
    check("run1 done drop", bus.done, 0);
`ifdef DRAW_SEQ_PIXCOUNT_EN
    check("run1 count hold", bus.pixel_count, 19700);
`endif
    // Run 2: clipping table on a manually driven shape stream
    fill_n = 3; shp_auto = 0;
    {bus.shp_done, bus.shp_x, bus.shp_y, bus.shp_colour, bus.shp_plot} = '0;
    bus.start = 1; bus.colour = 3'b101; bus.centre_x = 40; bus.centre_y = 30; bus.diameter = 60;
    tick();
`ifdef DRAW_SEQ_PIXCOUNT_EN
    check("run2 count clear", bus.pixel_count, 0);
`endif
    for (int i = 0; i < 100 && !bus.shp_start; i++) tick();
    check("run2 shp_start", bus.shp_start, 1);
    for (int i = 0; i < 7; i++) begin
      bus.shp_x = tbl[i].x; bus.shp_y = tbl[i].y; bus.shp_colour = tbl[i].c; bus.shp_plot = tbl[i].p;
      tick();
      check($sformatf("pix%0d plot", i), bus.vga_plot, tbl[i].exp_p);
      check($sformatf("pix%0d xyc", i), {bus.vga_x, bus.vga_y, bus.vga_colour}, {tbl[i].x, tbl[i].y, tbl[i].c});
    end
    bus.shp_done = 1; bus.shp_x = 5; bus.shp_y = 5; bus.shp_colour = 6; bus.shp_plot = 1;
    tick();
    check("run2 last pix", bus.vga_plot, 1);
    check("run2 shp_start rel", bus.shp_start, 0);
    bus.start = 0;
    tick();
    check("run2 rel pix dropped", bus.vga_plot, 0);
    check("run2 done early drop", bus.done, 1);
    tick();
    check("run2 done exit", bus.done, 0);
    check("run2 no restart", bus.fill_start, 0);
`ifdef DRAW_SEQ_PIXCOUNT_EN
    check("run2 pixel_count", bus.pixel_count, 7);
`endif
    {bus.shp_done, bus.shp_x, bus.shp_y, bus.shp_colour, bus.shp_plot} = '0;
    // Watchdog on the TIMEOUT=50 instance
    wbus.start = 1;
    tick();
    check("wd fill_start", wbus.fill_start, 1);
    sh = 0;
    repeat (49) begin
      tick();
      sh |= wbus.shp_start;
    end
    check("wd not yet", wbus.done, 0);
    tick();
    sh |= wbus.shp_start;
    check("wd done", wbus.done, 1);
    check("wd error", wbus.error, 1);
    check("wd fill drop", wbus.fill_start, 0);
    check("wd no shape", sh, 0);
    wbus.start = 0;
    tick();
    check("wd idle done", wbus.done, 0);
    check("wd error kept", wbus.error, 1);
    wbus.fill_done = 1; wbus.shp_done = 1; wbus.start = 1;
    tick();
    check("wd restart error", wbus.error, 0);
    check("wd early done fs", wbus.fill_start, 1);
    tick();
    check("wd fill exit", {wbus.fill_start, wbus.shp_start}, 0);
    tick();
    check("wd shp_start", wbus.shp_start, 1);
    tick();
    tick();
    check("wd clean done", {wbus.done, wbus.error}, 2'b10);
    // Async reset in SHAPE, then a fresh run
    bus.start = 1; bus.colour = 3'b111; bus.centre_x = 9;
    tick();
    for (int i = 0; i < 100 && !bus.shp_start; i++) tick();
    check("rst3 shp_start", bus.shp_start, 1);
    bus.shp_x = 77; bus.shp_y = 3; bus.shp_plot = 1;
    tick();
    check("rst3 vga_x", bus.vga_x, 77);
    #2 rst_n = 0;
    #1;
    check("arst starts", {bus.fill_start, bus.shp_start}, 0);
    check("arst flags", {bus.done, bus.error}, 0);
    check("arst vga", {bus.vga_plot, bus.vga_x, bus.vga_y}, 0);
    check("arst cfg", {bus.shp_cfg_colour, bus.shp_centre_x}, 0);
    bus.shp_plot = 0; bus.shp_x = 0;
    #1 rst_n = 1;
    tick();
    check("arst refill", {bus.fill_start, bus.shp_start}, 2'b10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
